truth_table_eval: RTL and testbench

- Parametrised successor to the fixed 3-input truth-table gates: an N_IN-input logic function whose truth table is held in a register.
- The table is reloadable at run time through a serial configuration handshake.
- The output is settle-filtered: it updates only after the inputs have been stable for SETTLE cycles, which models gate propagation delay and suppresses glitches.
- It also keeps a saturating count of output transitions. Used as a drop-in reconfigurable gate in synthesised circuit netlists.

---
 rtl/cello_logic_pkg.sv | 16 +
 rtl/input_settle_filter.sv | 46 ++++
 rtl/truth_table_eval.sv | 146 ++++++++++++++
 tb/tb_truth_table_eval.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cello_logic_pkg.sv
// rtl/cello_logic_pkg.sv - shared types and helpers for the reconfigurable gate generators
package cello_logic_pkg;

  typedef enum logic [1:0] {
    RUN,
    LOAD,
    COMMIT
  } cfg_state_t;

  localparam logic [7:0] TT_DEFAULT_3 = 8'h40;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/input_settle_filter.sv
// rtl/input_settle_filter.sv - registers an input word and counts cycles it has been stable
module input_settle_filter #(
  parameter int W      = 3,
  parameter int SETTLE = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [W-1:0]                     in,
  output logic [W-1:0]                     in_q,
  output logic [$clog2(SETTLE+1)-1:0]      stable_cnt,
  output logic                             settled,
  output logic                             dropped
);

  localparam int            CW      = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);

  logic [W-1:0]  sample_q, sample_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sample_d = in;
    dropped  = (in != sample_q);
    cnt_d    = cnt_q;
    if (dropped) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      cnt_q    <= '0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_q       = sample_q;
  assign stable_cnt = cnt_q;
  assign settled    = (cnt_q == CNT_MAX);

endmodule

// File: rtl/truth_table_eval.sv
// rtl/truth_table_eval.sv - N-input truth-table gate with serial table reload and settle-filtered output
module truth_table_eval
  import cello_logic_pkg::*;
#(
  parameter int                          N_IN    = 3,
  parameter int                          SETTLE  = 4,
  parameter logic [tt_width(N_IN)-1:0]   TT_INIT = TT_DEFAULT_3,
  parameter int                          CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   in,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  output logic              cfg_ready,
  input  logic              cfg_abort,
  output logic              cfg_done,
  output logic              out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_toggles
);

  localparam int              TT_W       = tt_width(N_IN);
  localparam int              SC_W       = $clog2(SETTLE + 1);
  localparam logic [SC_W-1:0] SETTLE_PRE = SC_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_BIT   = N_IN'(TT_W - 1);

  logic [N_IN-1:0] in_q;
  logic [SC_W-1:0] stable_cnt;
  logic            settled;
  logic            dropped;
  logic            settle_now;

  input_settle_filter #(
    .W      (N_IN),
    .SETTLE (SETTLE)
  ) u_filter (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .in_q       (in_q),
    .stable_cnt (stable_cnt),
    .settled    (settled),
    .dropped    (dropped)
  );

  cfg_state_t       state_q, state_d;
  logic [TT_W-1:0]  tt_q, tt_d;
  logic [TT_W-1:0]  shadow_q, shadow_d;
  logic [N_IN-1:0]  bit_cnt_q, bit_cnt_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_done_q, cfg_done_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] toggles_q, toggles_d;
  logic             accept;

  // Config loader: abort in LOAD outranks a simultaneous bit.
  always_comb begin
    state_d    = state_q;
    tt_d       = tt_q;
    shadow_d   = shadow_q;
    bit_cnt_d  = bit_cnt_q;
    cfg_done_d = 1'b0;
    accept     = cfg_valid && cfg_ready_q;
    case (state_q)
      RUN: begin
        if (accept) begin
          shadow_d    = '0;
          shadow_d[0] = cfg_bit;
          bit_cnt_d   = N_IN'(1);
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          shadow_d  = '0;
          bit_cnt_d = '0;
          state_d   = RUN;
        end else if (accept) begin
          shadow_d[bit_cnt_q] = cfg_bit;
          bit_cnt_d           = bit_cnt_q + N_IN'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = COMMIT;
            cfg_done_d = 1'b1;
          end
        end
      end
      COMMIT: begin
        tt_d      = shadow_q;
        bit_cnt_d = '0;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
    cfg_ready_d = (state_d != COMMIT);
  end

  // Once settled, out tracks the live table so a commit lands one edge later.
  always_comb begin
    settle_now  = !dropped && (settled || stable_cnt == SETTLE_PRE);
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (dropped) begin
      out_valid_d = 1'b0;
    end else if (settle_now) begin
      out_d       = tt_q[in_q];
      out_valid_d = 1'b1;
    end
    toggles_d = toggles_q;
    if (out_d != out_q && toggles_q != '1) begin
      toggles_d = toggles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      tt_q        <= TT_INIT;
      shadow_q    <= '0;
      bit_cnt_q   <= '0;
      cfg_ready_q <= 1'b1;
      cfg_done_q  <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      toggles_q   <= '0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      shadow_q    <= shadow_d;
      bit_cnt_q   <= bit_cnt_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_done_q  <= cfg_done_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      toggles_q   <= toggles_d;
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign cfg_done    = cfg_done_q;
  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign out_toggles = toggles_q;

endmodule

// File: tb/tb_truth_table_eval.sv
// tb/tb_truth_table_eval.sv - scoreboard bench for truth_table_eval
module tb_truth_table_eval;

  typedef struct packed {
    logic       o;
    logic [7:0] t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_m = 3'b000;
  logic [2:0] in_s = 3'b000;
  logic       cfg_valid = 1'b0, cfg_bit = 1'b0, cfg_abort = 1'b0;
  logic       s_cv = 1'b0, s_cb = 1'b0, s_ca = 1'b0;
  logic       cfg_ready, cfg_done, out_m, out_valid_m;
  logic [7:0] tog_m;
  logic       s_ready, s_done, s_out, s_valid;
  logic [1:0] s_tog;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic done_q[$];
  logic pv = 1'b0, po = 1'b0;

  truth_table_eval u_dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in_m),
    .cfg_valid   (cfg_valid),
    .cfg_bit     (cfg_bit),
    .cfg_ready   (cfg_ready),
    .cfg_abort   (cfg_abort),
    .cfg_done    (cfg_done),
    .out         (out_m),
    .out_valid   (out_valid_m),
    .out_toggles (tog_m)
  );

  truth_table_eval #(.CNT_W(2)) u_sat (
    .clk         (clk),
    .rst         (rst),
    .in          (in_s),
    .cfg_valid   (s_cv),
    .cfg_bit     (s_cb),
    .cfg_ready   (s_ready),
    .cfg_abort   (s_ca),
    .cfg_done    (s_done),
    .out         (s_out),
    .out_valid   (s_valid),
    .out_toggles (s_tog)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every settled output event and every commit pulse consumes one expectation.
  always @(negedge clk) begin
    exp_t e;
    logic r;
    if (rst) begin
      pv = 1'b0;
      po = 1'b0;
    end else begin
      if (out_valid_m && (!pv || out_m != po)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_event: out=%0b toggles=%0d, none expected", out_m, tog_m);
        end else begin
          e = exp_q.pop_front();
          chk("event_out", {31'd0, out_m}, {31'd0, e.o});
          chk("event_toggles", {24'd0, tog_m}, {24'd0, e.t});
        end
      end
      if (cfg_done) begin
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cfg_done: cfg_ready=%0b, none expected", cfg_ready);
        end else begin
          r = done_q.pop_front();
          chk("done_ready_low", {31'd0, cfg_ready}, {31'd0, r});
        end
      end
      pv = out_valid_m;
      po = out_m;
    end
  end

  initial begin
    logic [7:0] bits;
    tick(2);
    chk("rst_out", {31'd0, out_m}, 0);
    chk("rst_valid", {31'd0, out_valid_m}, 0);
    chk("rst_toggles", {24'd0, tog_m}, 0);
    chk("rst_ready", {31'd0, cfg_ready}, 1);
    chk("rst_done", {31'd0, cfg_done}, 0);

    // settle latency
    rst  = 1'b0;
    in_m = 3'b110;
    exp_q.push_back('{o: 1'b1, t: 8'd1});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("settle_early", {30'd0, out_valid_m, out_m}, 2'b00);
    end
    tick();
    chk("settle_out", {30'd0, out_valid_m, out_m}, 2'b11);
    chk("settle_toggles", {24'd0, tog_m}, 1);

    // glitch suppression
    for (int i = 0; i < 10; i++) begin
      in_m = (i % 2 == 0) ? 3'b111 : 3'b110;
      for (int j = 0; j < 2; j++) begin
        tick();
        chk("glitch_hold", {30'd0, out_valid_m, out_m}, 2'b01);
      end
    end
    chk("glitch_toggles", {24'd0, tog_m}, 1);
    exp_q.push_back('{o: 1'b1, t: 8'd1});
    tick(6);
    chk("glitch_resettle", {30'd0, out_valid_m, out_m}, 2'b11);

    // reload with XOR table
    in_m = 3'b001;
    exp_q.push_back('{o: 1'b0, t: 8'd2});
    tick(6);
    chk("pre_load_out", {30'd0, out_valid_m, out_m}, 2'b10);
    bits = 8'h96;
    done_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("load_ready", {31'd0, cfg_ready}, 1);
      cfg_valid = 1'b1;
      cfg_bit   = bits[i];
      tick();
      if (i < 7) chk("load_done_early", {31'd0, cfg_done}, 0);
    end
    cfg_valid = 1'b0;
    chk("commit_ready", {31'd0, cfg_ready}, 0);
    chk("commit_done", {31'd0, cfg_done}, 1);
    exp_q.push_back('{o: 1'b1, t: 8'd3});
    tick();
    chk("post_commit_ready", {31'd0, cfg_ready}, 1);
    chk("post_commit_done", {31'd0, cfg_done}, 0);
    chk("commit_edge_old_table", {30'd0, out_valid_m, out_m}, 2'b10);
    tick();
    chk("new_table_out", {30'd0, out_valid_m, out_m}, 2'b11);
    chk("new_table_toggles", {24'd0, tog_m}, 3);

    // async reset mid-load
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      tick();
    end
    #3;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    #1;
    chk("async_rst_out", {30'd0, out_valid_m, out_m}, 2'b00);
    chk("async_rst_done", {31'd0, cfg_done}, 0);
    chk("async_rst_toggles", {24'd0, tog_m}, 0);
    in_m = 3'b110;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back('{o: 1'b1, t: 8'd1});
    tick(6);
    chk("tt_init_restored", {30'd0, out_valid_m, out_m}, 2'b11);

    // abort a partial load
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      tick();
    end
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    chk("abort_out", {30'd0, out_valid_m, out_m}, 2'b11);
    chk("abort_done", {31'd0, cfg_done}, 0);
    tick(2);
    chk("abort_hold", {30'd0, out_valid_m, out_m}, 2'b11);
    done_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      tick();
      if (i < 7) chk("ff_done_early", {31'd0, cfg_done}, 0);
    end
    cfg_valid = 1'b0;
    chk("ff_done", {31'd0, cfg_done}, 1);
    tick(2);
    in_m = 3'b000;
    exp_q.push_back('{o: 1'b1, t: 8'd1});
    tick(6);
    chk("ff_table_out", {30'd0, out_valid_m, out_m}, 2'b11);
    chk("ff_table_toggles", {24'd0, tog_m}, 1);

    // counter saturation on the 2-bit instance
    for (int t = 1; t <= 5; t++) begin
      in_s = (t % 2 == 1) ? 3'b110 : 3'b000;
      tick(6);
      chk("sat_out", {31'd0, s_out}, t % 2);
      chk("sat_toggles", {30'd0, s_tog}, (t < 3) ? t : 3);
    end

    chk("exp_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
